// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier, unsigned or two's complement, with
// valid/ready handshakes. One product every WIDTH+2 cycles with a single adder.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mag_a_q, mag_a_d;
  logic [WIDTH-1:0]    mag_b_q, mag_b_d;
  logic                neg_q, neg_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  p_q, p_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                b_bit;
  logic [2*WIDTH-1:0]  addend;
  logic [2*WIDTH-1:0]  acc_next;

  // The single adder: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    b_bit    = |(mag_b_q & (WIDTH'(1) << cnt_q));
    addend   = b_bit ? ({{WIDTH{1'b0}}, mag_a_q} << cnt_q) : '0;
    acc_next = acc_q + addend;
  end

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
          mag_a_d = (signed_mode && A[WIDTH-1]) ? -A : A;
          mag_b_d = (signed_mode && B[WIDTH-1]) ? -B : B;
          neg_d   = signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          p_d     = neg_q ? -acc_next : acc_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign P = p_q;

endmodule
